// File: rtl/mod_pkg.sv
// Shared definitions for the modulo adder datapath: FSM encodings and default sizing.
// No logic; no latency; no backpressure.
// Consumers import mod_pkg::* and derive their own localparams from the defaults.
package mod_pkg;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_MOD   = 1000;
  localparam int DEF_CHUNK = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit ripple-carry adder built from fa cells.
// Combinational, zero latency.
// No backpressure.
module add_chunk #(
  parameter int CHUNK = 2
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
// Combinational, zero latency.
// No backpressure.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_mod_adder.sv
// Modulo-MOD adder/accumulator: CHUNK bits per cycle through a registered carry, then one -MOD reduction.
// Latency: out_valid rises after edge accept+NCHUNK+1; one op per NCHUNK+3 cycles.
// Backpressure: in_ready low while busy; result held in DONE until out_ready.
module seq_mod_adder
  import mod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MOD   = DEF_MOD,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   raw_sum,
  output logic             wrapped,
  output logic             range_err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MOD);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q, acc_q, result_q;
  logic [WIDTH:0]    sum_q, raw_sum_q;
  logic              carry_q, rerr_pend_q;
  logic              wrapped_q, range_err_q, out_valid_q, in_ready_q;

  logic [CHUNK-1:0]  sl_a_d, sl_b_d, sl_s_d;
  logic              sl_c_d;
  logic [WIDTH:0]    sum_d, diff_d;
  logic [WIDTH-1:0]  b_eff_d, result_d;
  logic              wrapped_d, rerr_d;

  // One shared chunk adder; idx_q steers which operand slice feeds it.
  always_comb begin
    sl_a_d = '0;
    sl_b_d = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        sl_a_d = a_q[i*CHUNK +: CHUNK];
        sl_b_d = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  add_chunk #(.CHUNK(CHUNK)) u_add (
    .cin  (carry_q),
    .a    (sl_a_d),
    .b    (sl_b_d),
    .sum  (sl_s_d),
    .cout (sl_c_d)
  );

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) sum_d[i*CHUNK +: CHUNK] = sl_s_d;
    end
    if (idx_q == LAST_IDX) sum_d[WIDTH] = sl_c_d;
  end

  always_comb begin
    b_eff_d   = acc_mode ? acc_q : b;
    rerr_d    = ({1'b0, a} >= MOD_W) | ({1'b0, b_eff_d} >= MOD_W);
    diff_d    = sum_q - MOD_W;
    wrapped_d = (sum_q >= MOD_W);
    result_d  = wrapped_d ? diff_d[WIDTH-1:0] : sum_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      sum_q       <= '0;
      raw_sum_q   <= '0;
      carry_q     <= 1'b0;
      rerr_pend_q <= 1'b0;
      wrapped_q   <= 1'b0;
      range_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      // Clear first so the REDUCE write below takes priority on the same edge.
      if (acc_clr) acc_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q         <= a;
            b_q         <= b_eff_d;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            rerr_pend_q <= rerr_d;
            in_ready_q  <= 1'b0;
            state_q     <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_q   <= sum_d;
          carry_q <= sl_c_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= ST_REDUCE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ST_REDUCE: begin
          raw_sum_q   <= sum_q;
          result_q    <= result_d;
          wrapped_q   <= wrapped_d;
          range_err_q <= rerr_pend_q;
          acc_q       <= result_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign raw_sum   = raw_sum_q;
  assign wrapped   = wrapped_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_seq_mod_adder.sv
// Bench for seq_mod_adder: scoreboard of expected results against delivered outputs,
// with latency, backpressure, accumulate and mid-op reset scenarios.
module tb_seq_mod_adder;

  localparam int NCHUNK = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [9:0]  a, b;
  logic        acc_mode, acc_clr;
  logic        out_valid, out_ready;
  logic [9:0]  result;
  logic [10:0] raw_sum;
  logic        wrapped, range_err;

  seq_mod_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .raw_sum   (raw_sum),
    .wrapped   (wrapped),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  res;
    logic [10:0] raw;
    logic        wr;
    logic        rerr;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [9:0] model_acc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [9:0] ai, input logic [9:0] bi, input logic mode);
    logic [9:0]  be;
    logic [10:0] raw, d;
    exp_t        e;
    be     = mode ? model_acc : bi;
    raw    = {1'b0, ai} + {1'b0, be};
    d      = raw - 11'd1000;
    e.raw  = raw;
    e.wr   = (raw >= 11'd1000);
    e.res  = e.wr ? d[9:0] : raw[9:0];
    e.rerr = (ai >= 10'd1000) || (be >= 10'd1000);
    return e;
  endfunction

  // Entered and left at a negedge.
  task automatic run_op(input logic [9:0] ai, input logic [9:0] bi, input logic mode,
                        input logic clr, input int hold, input bit junk);
    int   lat;
    exp_t e;
    logic [9:0] r0;
    if (!in_ready) begin
      chk("in_ready_before_op", 32'(in_ready), 32'd1);
      return;
    end
    a = ai; b = bi; acc_mode = mode; acc_clr = clr; in_valid = 1'b1;
    out_ready = (hold == 0);
    e = model(ai, bi, mode);
    sb_q.push_back(e);
    model_acc = e.res;
    @(posedge clk);
    lat = 0;
    while (1) begin
      @(negedge clk);
      acc_clr = 1'b0;
      if (junk && lat >= 1 && lat <= 3) begin
        in_valid = 1'b1; a = ~ai; b = ~bi; acc_mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (lat == 2) chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_valid) break;
      if (lat > 40) begin
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        return;
      end
      @(posedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(NCHUNK + 1));
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(r0));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk("result", 32'(result), 32'(e.res));
    chk("raw_sum", 32'(raw_sum), 32'(e.raw));
    chk("wrapped", 32'(wrapped), 32'(e.wr));
    chk("range_err", 32'(range_err), 32'(e.rerr));
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_result_kept", 32'(result), 32'(e.res));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_raw_sum", 32'(raw_sum), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);

    run_op(10'd123, 10'd456, 1'b0, 1'b0, 0, 1'b0);
    chk("t1_result_579", 32'(result), 32'd579);
    run_op(10'd999, 10'd1, 1'b0, 1'b0, 0, 1'b0);
    chk("t2_raw_1000", 32'(raw_sum), 32'd1000);
    chk("t2_result_0", 32'(result), 32'd0);

    acc_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_clr = 1'b0;
    model_acc = '0;
    run_op(10'd600, 10'd0, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_acc_600", 32'(result), 32'd600);
    run_op(10'd500, 10'd0, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_acc_100", 32'(result), 32'd100);
    acc_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_clr = 1'b0;
    model_acc = '0;
    run_op(10'd7, 10'd0, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_acc_7", 32'(result), 32'd7);
    // clear coinciding with accept: the op still sees the old accumulator
    run_op(10'd10, 10'd0, 1'b1, 1'b1, 0, 1'b0);
    chk("clr_at_accept_17", 32'(result), 32'd17);

    run_op(10'd1023, 10'd1023, 1'b0, 1'b0, 0, 1'b0);
    chk("t4_raw_2046", 32'(raw_sum), 32'd2046);
    chk("t4_result_22", 32'(result), 32'd22);
    run_op(10'd5, 10'd1010, 1'b0, 1'b0, 0, 1'b0);

    run_op(10'd300, 10'd400, 1'b0, 1'b0, 10, 1'b1);

    // reset in the middle of ADD drops the op
    in_valid = 1'b1; a = 10'd100; b = 10'd200; acc_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_acc = '0;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_result", 32'(result), 32'd0);
    chk("t6_raw_sum", 32'(raw_sum), 32'd0);
    out_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_dropped", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    run_op(10'd3, 10'd0, 1'b1, 1'b0, 0, 1'b0);
    chk("t6_acc_cleared", 32'(result), 32'd3);
    run_op(10'd5, 10'd5, 1'b0, 1'b0, 0, 1'b0);
    chk("t6_result_10", 32'(result), 32'd10);

    for (int k = 0; k < 8; k++) begin
      run_op(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
             1'($urandom_range(0, 1)), 1'b0, k % 3, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
